// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator result FIFO: register offsets,
// STATUS/CTRL bit positions and default sizing.
package accum_pkg;

    localparam int FIFO_DEPTH = 8;
    localparam int DROP_CNT_W = 8;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RSVD   = 2'd3
    } reg_addr_e;

    // STATUS layout; the occupancy count sits in [AW:0]
    localparam int ST_EMPTY_BIT = 8;
    localparam int ST_FULL_BIT  = 9;
    localparam int ST_OVF_BIT   = 10;
    localparam int ST_UDF_BIT   = 11;
    localparam int ST_DROP_LSB  = 16;

    // CTRL layout; the threshold sits in [AW:0]
    localparam int CTRL_THR_EN_BIT = 8;
    localparam int CTRL_OVF_EN_BIT = 9;
    localparam int CTRL_FLUSH_BIT  = 31;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, simultaneous push/pop and a
// flush that overrides everything. Reports pushes it had to drop.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_o,
    output logic [AW:0]      count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             drop_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && !flush_i && (!full_o || do_pop);
    assign drop_o  = push_i && !flush_i && full_o && !do_pop;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // NOTE: storage has no reset; an entry is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/accum_result_fifo.sv
// Captures accumulator results into a FIFO drained over Wishbone, with
// sticky overflow/underflow flags, a drop counter and a level interrupt.
module accum_result_fifo
    import accum_pkg::*;
#(
    parameter int BITS  = 32,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    input  logic [BITS-1:0] in_data,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    output logic            irq
);

    logic                  ack_q;
    logic [31:0]           dat_q;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;
    logic [AW:0]           thr_q;
    logic                  thr_en_q, ovf_en_q, irq_q;

    logic [BITS-1:0] fifo_head;
    logic [AW:0]     fifo_count;
    logic            fifo_full, fifo_empty, fifo_drop;

    reg_addr_e   adr;
    logic        access, rd, wr, pop, flush, w1c_ovf, w1c_udf;
    logic [31:0] status_w, ctrl_w, rdata;
    logic        unused_ok;

    assign adr    = reg_addr_e'(wbs_adr_i[3:2]);
    assign access = wbs_cyc_i && wbs_stb_i && !ack_q;
    assign rd     = access && !wbs_we_i;
    assign wr     = access && wbs_we_i;

    assign pop     = rd && (adr == REG_DATA);
    assign flush   = wr && (adr == REG_CTRL) && wbs_sel_i[3] && wbs_dat_i[CTRL_FLUSH_BIT];
    assign w1c_ovf = wr && (adr == REG_STATUS) && wbs_sel_i[1] && wbs_dat_i[ST_OVF_BIT];
    assign w1c_udf = wr && (adr == REG_STATUS) && wbs_sel_i[1] && wbs_dat_i[ST_UDF_BIT];

    assign unused_ok = ^{wbs_adr_i, wbs_dat_i, wbs_sel_i[2]};

    sync_fifo #(
        .WIDTH (BITS),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (in_valid),
        .data_i  (in_data),
        .pop_i   (pop),
        .flush_i (flush),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop)
    );

    always_comb begin
        status_w = '0;
        status_w[AW:0]                          = fifo_count;
        status_w[ST_EMPTY_BIT]                  = fifo_empty;
        status_w[ST_FULL_BIT]                   = fifo_full;
        status_w[ST_OVF_BIT]                    = ovf_q;
        status_w[ST_UDF_BIT]                    = udf_q;
        status_w[ST_DROP_LSB +: DROP_CNT_W]     = drop_q;

        ctrl_w = '0;
        ctrl_w[AW:0]            = thr_q;
        ctrl_w[CTRL_THR_EN_BIT] = thr_en_q;
        ctrl_w[CTRL_OVF_EN_BIT] = ovf_en_q;

        case (adr)
            REG_DATA:   rdata = fifo_empty ? '0 : fifo_head;
            REG_STATUS: rdata = status_w;
            REG_CTRL:   rdata = ctrl_w;
            default:    rdata = '0;
        endcase
    end

    // NOTE: combinational next-state logic uses blocking '=' so later lines see
    // earlier ones; the registers below use '<=' only.
    always_comb begin
        drop_d = drop_q;
        if (w1c_ovf) drop_d = '0;
        if (fifo_drop && (drop_d != '1)) drop_d = drop_d + 1'b1;
        ovf_d = (ovf_q && !w1c_ovf) || fifo_drop;
        udf_d = (udf_q && !w1c_udf) || (pop && fifo_empty);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            drop_q   <= '0;
            thr_q    <= '0;
            thr_en_q <= 1'b0;
            ovf_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ack_q  <= access;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
            drop_q <= drop_d;
            if (rd) dat_q <= rdata;
            if (wr && (adr == REG_CTRL)) begin
                if (wbs_sel_i[0]) thr_q <= wbs_dat_i[AW:0];
                if (wbs_sel_i[1]) begin
                    thr_en_q <= wbs_dat_i[CTRL_THR_EN_BIT];
                    ovf_en_q <= wbs_dat_i[CTRL_OVF_EN_BIT];
                end
            end
            irq_q <= (thr_en_q && (fifo_count >= thr_q) && (thr_q != '0))
                  || (ovf_en_q && ovf_q);
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_accum_result_fifo.sv
// Directed bench for accum_result_fifo: a vector table for register and FIFO
// behaviour plus hand sequences for the multi-cycle corner cases.
module tb_accum_result_fifo;

    typedef enum logic [1:0] {OP_PUSH, OP_RD, OP_WR} op_e;

    typedef struct {
        op_e         op;
        logic [1:0]  adr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = '0;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        irq;

    int tests = 0;
    int fails = 0;

    accum_result_fifo dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] v);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // One Wishbone access; optionally pulses in_valid on the access edge.
    task automatic wb_xfer(input logic we, input logic [1:0] adr, input logic [31:0] wdat,
                           input logic [3:0] sel, input logic pv, input logic [31:0] pdat,
                           output logic [31:0] rdat);
        bit got = 1'b0;
        rdat = '0;
        @(negedge clk);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = {28'b0, adr, 2'b00};
        wbs_dat_i = wdat;
        wbs_sel_i = sel;
        in_valid  = pv;
        in_data   = pdat;
        for (int k = 0; k < 4 && !got; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (wbs_ack_o) begin
                got  = 1'b1;
                rdat = wbs_dat_o;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL wb_ack_timeout: got no ack, expected ack within 4 cycles (adr=%0d)", adr);
        end
    endtask

    task automatic rd_chk(input string name, input logic [1:0] adr, input logic [31:0] exp);
        logic [31:0] r;
        wb_xfer(1'b0, adr, '0, 4'hF, 1'b0, '0, r);
        check(name, r, exp);
    endtask

    task automatic wr(input logic [1:0] adr, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] r;
        wb_xfer(1'b1, adr, d, sel, 1'b0, '0, r);
    endtask

    function automatic vec_t mk(op_e op, logic [1:0] adr, logic [31:0] data,
                                logic [3:0] sel, logic [31:0] exp);
        vec_t v;
        v.op = op; v.adr = adr; v.data = data; v.sel = sel; v.exp = exp;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        logic [31:0] r;

        // Vector table: basic order, overflow, W1C, byte lanes, underflow
        vecs.push_back(mk(OP_RD,   2'd1, 0, 4'hF, 32'h0000_0100));
        vecs.push_back(mk(OP_PUSH, 0, 32'h11, 0, 0));
        vecs.push_back(mk(OP_PUSH, 0, 32'h22, 0, 0));
        vecs.push_back(mk(OP_PUSH, 0, 32'h33, 0, 0));
        vecs.push_back(mk(OP_RD,   2'd1, 0, 4'hF, 32'h0000_0003));
        vecs.push_back(mk(OP_RD,   2'd0, 0, 4'hF, 32'h11));
        vecs.push_back(mk(OP_RD,   2'd0, 0, 4'hF, 32'h22));
        vecs.push_back(mk(OP_RD,   2'd0, 0, 4'hF, 32'h33));
        vecs.push_back(mk(OP_RD,   2'd1, 0, 4'hF, 32'h0000_0100));
        for (int i = 1; i <= 10; i++) vecs.push_back(mk(OP_PUSH, 0, 32'(i), 0, 0));
        vecs.push_back(mk(OP_RD,   2'd1, 0, 4'hF, 32'h0002_0608));
        for (int i = 1; i <= 8; i++) vecs.push_back(mk(OP_RD, 2'd0, 0, 4'hF, 32'(i)));
        vecs.push_back(mk(OP_RD,   2'd1, 0, 4'hF, 32'h0002_0500));
        vecs.push_back(mk(OP_WR,   2'd1, 32'h0000_0400, 4'hF, 0));
        vecs.push_back(mk(OP_RD,   2'd1, 0, 4'hF, 32'h0000_0100));
        vecs.push_back(mk(OP_RD,   2'd2, 0, 4'hF, 32'h0));
        vecs.push_back(mk(OP_WR,   2'd3, 32'hFFFF_FFFF, 4'hF, 0));
        vecs.push_back(mk(OP_RD,   2'd3, 0, 4'hF, 32'h0));
        vecs.push_back(mk(OP_RD,   2'd0, 0, 4'hF, 32'h0));
        vecs.push_back(mk(OP_RD,   2'd1, 0, 4'hF, 32'h0000_0900));
        vecs.push_back(mk(OP_WR,   2'd1, 32'h0000_0800, 4'hF, 0));
        vecs.push_back(mk(OP_RD,   2'd1, 0, 4'hF, 32'h0000_0100));
        vecs.push_back(mk(OP_WR,   2'd2, 32'h0000_0305, 4'b0001, 0));
        vecs.push_back(mk(OP_RD,   2'd2, 0, 4'hF, 32'h0000_0005));
        vecs.push_back(mk(OP_WR,   2'd2, 32'h0000_0300, 4'b0010, 0));
        vecs.push_back(mk(OP_RD,   2'd2, 0, 4'hF, 32'h0000_0305));
        vecs.push_back(mk(OP_WR,   2'd2, 32'h0000_0000, 4'hF, 0));
        vecs.push_back(mk(OP_RD,   2'd2, 0, 4'hF, 32'h0));

        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_ack", {31'b0, wbs_ack_o}, 32'h0);
        check("reset_dat", wbs_dat_o, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].op)
                OP_PUSH: push(vecs[i].data);
                OP_RD:   rd_chk($sformatf("vec%0d", i), vecs[i].adr, vecs[i].exp);
                default: wr(vecs[i].adr, vecs[i].data, vecs[i].sel);
            endcase
        end

        // Full FIFO: pop and push on the same edge
        for (int i = 0; i < 8; i++) push(32'hA0 + 32'(i));
        rd_chk("full_status", 2'd1, 32'h0000_0208);
        wb_xfer(1'b0, 2'd0, '0, 4'hF, 1'b1, 32'hB0, r);
        check("full_pushpop_head", r, 32'hA0);
        rd_chk("full_pushpop_status", 2'd1, 32'h0000_0208);
        for (int i = 1; i < 8; i++) rd_chk($sformatf("full_drain%0d", i), 2'd0, 32'hA0 + 32'(i));
        rd_chk("full_drain_last", 2'd0, 32'hB0);
        rd_chk("full_drain_status", 2'd1, 32'h0000_0100);

        // Threshold interrupt
        wr(2'd2, 32'h0000_0104, 4'hF);
        for (int i = 0; i < 3; i++) push(32'hC0 + 32'(i));
        @(negedge clk);
        check("thr_irq_below", {31'b0, irq}, 32'h0);
        push(32'hC3);
        check("thr_irq_not_yet", {31'b0, irq}, 32'h0);
        @(negedge clk);
        check("thr_irq_set", {31'b0, irq}, 32'h1);
        rd_chk("thr_pop", 2'd0, 32'hC0);
        @(negedge clk);
        check("thr_irq_clear", {31'b0, irq}, 32'h0);
        wr(2'd2, 32'h0, 4'hF);
        for (int i = 1; i < 4; i++) rd_chk($sformatf("thr_drain%0d", i), 2'd0, 32'hC0 + 32'(i));

        // Empty read with coincident push, then flush with coincident push
        wb_xfer(1'b0, 2'd0, '0, 4'hF, 1'b1, 32'h55, r);
        check("empty_pushpop_data", r, 32'h0);
        rd_chk("empty_pushpop_status", 2'd1, 32'h0000_0801);
        wr(2'd1, 32'h0000_0800, 4'hF);
        for (int i = 0; i < 4; i++) push(32'h56 + 32'(i));
        rd_chk("preflush_status", 2'd1, 32'h0000_0005);
        wb_xfer(1'b1, 2'd2, 32'h8000_0000, 4'hF, 1'b1, 32'h66, r);
        rd_chk("flush_status", 2'd1, 32'h0000_0100);
        rd_chk("flush_ctrl_reads0", 2'd2, 32'h0);

        // Overflow interrupt and drop counter saturation
        wr(2'd2, 32'h0000_0200, 4'hF);
        for (int i = 0; i < 9; i++) push(32'h70 + 32'(i));
        check("ovf_irq_not_yet", {31'b0, irq}, 32'h0);
        @(negedge clk);
        check("ovf_irq_set", {31'b0, irq}, 32'h1);
        rd_chk("ovf_status", 2'd1, 32'h0001_0608);
        for (int i = 0; i < 260; i++) push(32'h90);
        rd_chk("drop_saturate", 2'd1, 32'h00FF_0608);
        wr(2'd1, 32'h0000_0400, 4'hF);
        @(negedge clk);
        check("ovf_irq_clear", {31'b0, irq}, 32'h0);
        rd_chk("ovf_cleared_status", 2'd1, 32'h0000_0208);
        wr(2'd2, 32'h8000_0000, 4'hF);
        rd_chk("flush2_status", 2'd1, 32'h0000_0100);

        // Reset in the middle of a DATA read with 6 entries queued
        for (int i = 0; i < 6; i++) push(32'hE0 + 32'(i));
        wr(2'd2, 32'h0000_0102, 4'hF);
        @(negedge clk);
        check("pre_reset_irq", {31'b0, irq}, 32'h1);
        @(negedge clk);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_adr_i = 32'h0;
        @(posedge clk);
        #2;
        check("pre_reset_ack", {31'b0, wbs_ack_o}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("midreset_ack", {31'b0, wbs_ack_o}, 32'h0);
        check("midreset_irq", {31'b0, irq}, 32'h0);
        check("midreset_dat", wbs_dat_o, 32'h0);
        @(negedge clk);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        rd_chk("postreset_status", 2'd1, 32'h0000_0100);
        rd_chk("postreset_ctrl", 2'd2, 32'h0);
        check("postreset_irq", {31'b0, irq}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
